// File: rtl/serial_bus_arbiter.sv
// Two-master round-robin arbiter for the serial system bus. It grants the bus to one master at
// a time and registers the owner's serial valid/data lines onto the shared bus.
module serial_bus_arbiter #(
    parameter int TIMEOUT = 32,
    parameter int CNT_LEN = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_m1,
    input  logic       req_m2,
    input  logic       done_m1,
    input  logic       done_m2,
    input  logic       valid_m1,
    input  logic       data_m1,
    input  logic       valid_m2,
    input  logic       data_m2,
    output logic       grant_m1,
    output logic       grant_m2,
    output logic       busy_m1,
    output logic       busy_m2,
    output logic       bus_valid,
    output logic       bus_data,
    output logic [1:0] owner
);

    typedef enum logic [1:0] {
        IDLE,
        OWN_M1,
        OWN_M2,
        RELEASE
    } state_t;

    localparam logic [CNT_LEN-1:0] IDLE_LAST = CNT_LEN'(TIMEOUT - 1);

    state_t             state;
    logic               last_m2;
    logic [CNT_LEN-1:0] idle_cnt;

    logic pick_m1;
    logic pick_m2;
    logic timeout_hit;
    logic leave_m1;
    logic leave_m2;

    // Tie break favours the master that did not own the bus last.
    always_comb begin
        pick_m1     = req_m1 && (!req_m2 || last_m2);
        pick_m2     = req_m2 && (!req_m1 || !last_m2);
        timeout_hit = (idle_cnt == IDLE_LAST);
        leave_m1    = done_m1 || !req_m1 || (!valid_m1 && timeout_hit);
        leave_m2    = done_m2 || !req_m2 || (!valid_m2 && timeout_hit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_m2   <= 1'b1;
            idle_cnt  <= '0;
            grant_m1  <= 1'b0;
            grant_m2  <= 1'b0;
            busy_m1   <= 1'b0;
            busy_m2   <= 1'b0;
            bus_valid <= 1'b0;
            bus_data  <= 1'b0;
            owner     <= 2'd0;
        end else begin
            bus_valid <= 1'b0;
            bus_data  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_m1) begin
                        state     <= OWN_M1;
                        last_m2   <= 1'b0;
                        idle_cnt  <= '0;
                        grant_m1  <= 1'b1;
                        busy_m2   <= 1'b1;
                        owner     <= 2'd1;
                        bus_valid <= valid_m1;
                        bus_data  <= data_m1;
                    end else if (pick_m2) begin
                        state     <= OWN_M2;
                        last_m2   <= 1'b1;
                        idle_cnt  <= '0;
                        grant_m2  <= 1'b1;
                        busy_m1   <= 1'b1;
                        owner     <= 2'd2;
                        bus_valid <= valid_m2;
                        bus_data  <= data_m2;
                    end
                end
                OWN_M1: begin
                    // The sample on the leaving edge is still forwarded.
                    bus_valid <= valid_m1;
                    bus_data  <= data_m1;
                    if (leave_m1) begin
                        state    <= RELEASE;
                        grant_m1 <= 1'b0;
                        busy_m2  <= 1'b0;
                        owner    <= 2'd0;
                    end else if (valid_m1) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt != '1) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                OWN_M2: begin
                    bus_valid <= valid_m2;
                    bus_data  <= data_m2;
                    if (leave_m2) begin
                        state    <= RELEASE;
                        grant_m2 <= 1'b0;
                        busy_m1  <= 1'b0;
                        owner    <= 2'd0;
                    end else if (valid_m2) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt != '1) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Bench for serial_bus_arbiter: directed scenarios plus randomized traffic checked against a
// cycle-level ownership model.
module tb_serial_bus_arbiter;

    localparam int TIMEOUT = 8;
    localparam int CNT_LEN = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_m1 = 1'b0, req_m2 = 1'b0;
    logic       done_m1 = 1'b0, done_m2 = 1'b0;
    logic       valid_m1 = 1'b0, data_m1 = 1'b0;
    logic       valid_m2 = 1'b0, data_m2 = 1'b0;
    logic       grant_m1, grant_m2, busy_m1, busy_m2, bus_valid, bus_data;
    logic [1:0] owner;

    int total = 0;
    int bad = 0;

    // Model: who holds the bus, whether the one-cycle release gap is pending, who won last,
    // how many consecutive owned cycles had valid low, and the registered bus lines.
    int m_owner = 0;
    int m_last = 2;
    int m_quiet = 0;
    bit m_rel = 0;
    bit m_bv = 0;
    bit m_bd = 0;

    serial_bus_arbiter #(.TIMEOUT(TIMEOUT), .CNT_LEN(CNT_LEN)) dut (
        .clk(clk), .reset(reset),
        .req_m1(req_m1), .req_m2(req_m2),
        .done_m1(done_m1), .done_m2(done_m2),
        .valid_m1(valid_m1), .data_m1(data_m1),
        .valid_m2(valid_m2), .data_m2(data_m2),
        .grant_m1(grant_m1), .grant_m2(grant_m2),
        .busy_m1(busy_m1), .busy_m2(busy_m2),
        .bus_valid(bus_valid), .bus_data(bus_data),
        .owner(owner)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs_vec();
        return {grant_m1, grant_m2, busy_m1, busy_m2, bus_valid, bus_data, owner};
    endfunction

    function automatic logic [7:0] exp_vec();
        logic [1:0] o;
        o = 2'(m_owner);
        return {m_owner == 1, m_owner == 2, m_owner == 2, m_owner == 1, m_bv, m_bd, o};
    endfunction

    // Advance the model with the inputs about to be sampled, then let the DUT take the edge.
    task automatic tick();
        bit v, d, dn, rq;
        int win;
        if (reset) begin
            m_owner = 0; m_rel = 0; m_last = 2; m_quiet = 0; m_bv = 0; m_bd = 0;
        end else if (m_owner != 0) begin
            v  = (m_owner == 1) ? valid_m1 : valid_m2;
            d  = (m_owner == 1) ? data_m1 : data_m2;
            dn = (m_owner == 1) ? done_m1 : done_m2;
            rq = (m_owner == 1) ? req_m1 : req_m2;
            m_bv = v;
            m_bd = d;
            if (dn || !rq || (!v && m_quiet + 1 >= TIMEOUT)) begin
                m_owner = 0;
                m_rel = 1;
            end else begin
                m_quiet = v ? 0 : m_quiet + 1;
            end
        end else if (m_rel) begin
            m_rel = 0; m_bv = 0; m_bd = 0;
        end else begin
            m_bv = 0; m_bd = 0;
            win = 0;
            if (req_m1 && req_m2) win = (m_last == 1) ? 2 : 1;
            else if (req_m1) win = 1;
            else if (req_m2) win = 2;
            if (win != 0) begin
                m_owner = win;
                m_last = win;
                m_quiet = 0;
                m_bv = (win == 1) ? valid_m1 : valid_m2;
                m_bd = (win == 1) ? data_m1 : data_m2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_m1 = 0; req_m2 = 0; done_m1 = 0; done_m2 = 0;
        valid_m1 = 0; data_m1 = 0; valid_m2 = 0; data_m2 = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        req_m1 = 1; req_m2 = 1;
        reset = 1;
        tick();
        tick();
        total++;
        if (obs_vec() !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=%b", obs_vec(), 8'h00);
        end
        reset = 0;
        tick();
        total++;
        if (grant_m1 !== 1'b1 || owner !== 2'd1 || grant_m2 !== 1'b0) begin
            bad++;
            $display("FAIL reset_first_tie got grant_m1=%b grant_m2=%b owner=%0d want 1 0 1",
                     grant_m1, grant_m2, owner);
        end
    endtask

    task automatic test_round_robin();
        int want;
        do_reset();
        req_m1 = 1; req_m2 = 1;
        tick();
        want = 1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (owner !== 2'(want) || obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL rr_grant_%0d got owner=%0d vec=%b want owner=%0d vec=%b",
                         i, owner, obs_vec(), want, exp_vec());
            end
            valid_m1 = 1'($urandom); valid_m2 = 1'($urandom);
            tick();
            if (want == 1) done_m1 = 1; else done_m2 = 1;
            tick();
            done_m1 = 0; done_m2 = 0;
            total++;
            if (owner !== 2'd0 || grant_m1 !== 1'b0 || grant_m2 !== 1'b0) begin
                bad++;
                $display("FAIL rr_release_%0d got owner=%0d g1=%b g2=%b want 0 0 0",
                         i, owner, grant_m1, grant_m2);
            end
            tick();
            total++;
            if (owner !== 2'd0 || obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL rr_idle_%0d got vec=%b want=%b", i, obs_vec(), exp_vec());
            end
            tick();
            want = 3 - want;
        end
    endtask

    task automatic test_data_path();
        logic [3:0] pat;
        pat = 4'b1101;
        do_reset();
        req_m1 = 1; valid_m2 = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            valid_m1 = 1;
            data_m1 = pat[3-i];
            data_m2 = ~data_m2;
            tick();
            total++;
            if (bus_valid !== 1'b1 || bus_data !== pat[3-i] || owner !== 2'd1) begin
                bad++;
                $display("FAIL data_bit_%0d got valid=%b data=%b owner=%0d want 1 %b 1",
                         i, bus_valid, bus_data, owner, pat[3-i]);
            end
        end
        valid_m1 = 0; data_m1 = 0;
        tick();
        total++;
        if (bus_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL data_idle_line got vec=%b want=%b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_timeout();
        for (int pass = 0; pass < 2; pass++) begin
            int n;
            int want_n;
            want_n = (pass == 0) ? TIMEOUT : 13;
            do_reset();
            req_m2 = 1;
            tick();
            n = grant_m2 ? 1 : 0;
            for (int i = 1; i < 40; i++) begin
                valid_m2 = (pass == 1 && i == 5);
                tick();
                if (grant_m2) n++;
                else break;
            end
            valid_m2 = 0;
            total++;
            if (n !== want_n) begin
                bad++;
                $display("FAIL timeout_len_%0d got=%0d want=%0d", pass, n, want_n);
            end
            total++;
            if (owner !== 2'd0 || obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL timeout_release_%0d got vec=%b want=%b", pass, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_withdrawal();
        do_reset();
        req_m1 = 1;
        tick();
        req_m2 = 1;
        tick();
        total++;
        if (busy_m2 !== 1'b1 || grant_m2 !== 1'b0 || grant_m1 !== 1'b1) begin
            bad++;
            $display("FAIL wd_busy got busy_m2=%b grant_m2=%b grant_m1=%b want 1 0 1",
                     busy_m2, grant_m2, grant_m1);
        end
        req_m1 = 0;
        tick();
        total++;
        if (grant_m1 !== 1'b0 || busy_m2 !== 1'b0) begin
            bad++;
            $display("FAIL wd_drop got grant_m1=%b busy_m2=%b want 0 0", grant_m1, busy_m2);
        end
        tick();
        total++;
        if (grant_m2 !== 1'b0) begin
            bad++;
            $display("FAIL wd_gap got grant_m2=%b want 0", grant_m2);
        end
        tick();
        total++;
        if (grant_m2 !== 1'b1 || busy_m1 !== 1'b1 || owner !== 2'd2) begin
            bad++;
            $display("FAIL wd_handover got grant_m2=%b busy_m1=%b owner=%0d want 1 1 2",
                     grant_m2, busy_m1, owner);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_m2 = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            valid_m2 = 1; data_m2 = 1'($urandom);
            tick();
        end
        reset = 1; req_m2 = 0; req_m1 = 1;
        tick();
        total++;
        if (obs_vec() !== 8'h00) begin
            bad++;
            $display("FAIL midburst_reset got=%b want=%b", obs_vec(), 8'h00);
        end
        reset = 0; valid_m2 = 0;
        tick();
        total++;
        if (grant_m1 !== 1'b1 || owner !== 2'd1) begin
            bad++;
            $display("FAIL midburst_regrant got grant_m1=%b owner=%0d want 1 1", grant_m1, owner);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 99) < 2);
            req_m1   = ($urandom_range(0, 99) < 75);
            req_m2   = ($urandom_range(0, 99) < 75);
            done_m1  = ($urandom_range(0, 99) < 8);
            done_m2  = ($urandom_range(0, 99) < 8);
            valid_m1 = ($urandom_range(0, 99) < 40);
            valid_m2 = ($urandom_range(0, 99) < 40);
            data_m1  = 1'($urandom);
            data_m2  = 1'($urandom);
            tick();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random_cycle_%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_data_path();
        test_timeout();
        test_withdrawal();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
